// File: rtl/sfl_pkg.sv
// Shared definitions for serial_frame_loader.
//   - state encoding (also exposed as an enum for the FSM)
//   - default frame width and gap timeout
package sfl_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_TIMEOUT = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_SHIFT = S_SHIFT,
      ST_HOLD  = S_HOLD
   } state_e;

endpackage

// File: rtl/serial_frame_loader_if.sv
// Bus bundle for serial_frame_loader.
//   serial side : start, sdata, sval
//   parallel side: pdata, pvalid, pready
//   status      : busy, overrun, timeout_err
// slave  = the loader; master = whoever drives the stream and consumes words.
interface serial_frame_loader_if #(
   parameter int WIDTH = sfl_pkg::DEF_WIDTH
);
   logic             start;
   logic             sdata;
   logic             sval;
   logic [WIDTH-1:0] pdata;
   logic             pvalid;
   logic             pready;
   logic             busy;
   logic             overrun;
   logic             timeout_err;

   modport slave (
      input  start, sdata, sval, pready,
      output pdata, pvalid, busy, overrun, timeout_err
   );

   modport master (
      output start, sdata, sval, pready,
      input  pdata, pvalid, busy, overrun, timeout_err
   );
endinterface

// File: rtl/dff_bank_ar.sv
// WIDTH-wide D register with load enable and asynchronous active-low clear.
//   clk, rst_n : clock, async clear (active low)
//   en         : load d on the rising edge
//   d / q      : data in / registered data out
module dff_bank_ar #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  data_q <= '0;
      else if (en) data_q <= d;
   end

   assign q = data_q;
endmodule

// File: rtl/serial_frame_loader.sv
// Serial-in / parallel-out frame capture.
// After start, shifts WIDTH bits MSB-first (one per sval cycle), then holds the
// word on pdata with pvalid until the consumer takes it (pvalid & pready).
// A frame that sees TIMEOUT consecutive idle SHIFT cycles is aborted with a
// one-cycle timeout_err. start in HOLD without a same-cycle handshake is
// dropped and flagged with a one-cycle overrun. All outputs are registered.
//   clk, rst_n : clock, async active-low reset
//   io         : serial_frame_loader_if slave modport
module serial_frame_loader
   import sfl_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   serial_frame_loader_if.slave   io
);
   localparam int BCW = $clog2(WIDTH + 1);
   localparam int GCW = $clog2(TIMEOUT + 1);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
   localparam logic [BCW-1:0] BIT_MAX  = BCW'(WIDTH);
   localparam logic [GCW-1:0] GAP_LAST = GCW'(TIMEOUT - 1);
   localparam logic [GCW-1:0] GAP_MAX  = GCW'(TIMEOUT);

   state_e           state_q, state_d;
   logic [BCW-1:0]   bit_q, bit_d;
   logic [GCW-1:0]   gap_q, gap_d;
   logic             pvalid_q, pvalid_d;
   logic             busy_q, busy_d;
   logic             overrun_q, overrun_d;
   logic             tmo_q, tmo_d;

   // The shift register keeps only WIDTH-1 bits: the oldest bit of a full
   // frame goes straight from the shifted value into pdata, never back into
   // the shift register.
   logic             sh_en, pd_en;
   logic [WIDTH-2:0] sh_q, sh_d;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] pd_q;

   assign shifted = {sh_q, io.sdata};

   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      gap_d     = gap_q;
      sh_en     = 1'b0;
      sh_d      = shifted[WIDTH-2:0];
      pd_en     = 1'b0;
      overrun_d = 1'b0;
      tmo_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (io.start) begin
               state_d = ST_SHIFT;
               bit_d   = '0;
               gap_d   = '0;
               sh_en   = 1'b1;
               sh_d    = '0;
            end
         end
         ST_SHIFT: begin
            // A bit on the cycle the gap limit would hit takes priority.
            if (io.sval) begin
               sh_en = 1'b1;
               gap_d = '0;
               bit_d = (bit_q == BIT_MAX) ? bit_q : bit_q + 1'b1;
               if (bit_q == BIT_LAST) begin
                  pd_en   = 1'b1;
                  state_d = ST_HOLD;
               end
            end else if (gap_q == GAP_LAST) begin
               state_d = ST_IDLE;
               tmo_d   = 1'b1;
            end else begin
               gap_d = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (io.pready) begin
               if (io.start) begin
                  state_d = ST_SHIFT;
                  bit_d   = '0;
                  gap_d   = '0;
                  sh_en   = 1'b1;
                  sh_d    = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (io.start) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      pvalid_d = (state_d == ST_HOLD);
      busy_d   = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         bit_q     <= '0;
         gap_q     <= '0;
         pvalid_q  <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_q     <= bit_d;
         gap_q     <= gap_d;
         pvalid_q  <= pvalid_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
         tmo_q     <= tmo_d;
      end
   end

   dff_bank_ar #(.WIDTH(WIDTH - 1)) u_shreg (
      .clk(clk), .rst_n(rst_n), .en(sh_en), .d(sh_d), .q(sh_q)
   );

   dff_bank_ar #(.WIDTH(WIDTH)) u_pdata (
      .clk(clk), .rst_n(rst_n), .en(pd_en), .d(shifted), .q(pd_q)
   );

   assign io.pdata       = pd_q;
   assign io.pvalid      = pvalid_q;
   assign io.busy        = busy_q;
   assign io.overrun     = overrun_q;
   assign io.timeout_err = tmo_q;
endmodule

// File: tb/tb_serial_frame_loader.sv
// Directed bench for serial_frame_loader (WIDTH=8, TIMEOUT=16).
// Expected words are queued as frames are sent; a negedge monitor pops and
// compares on every pvalid&pready handshake and tallies status pulses.
module tb_serial_frame_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_frame_loader_if #(.WIDTH(8)) io ();

   serial_frame_loader #(.WIDTH(8), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .io(io.slave)
   );

   int n_vec = 0;
   int n_err = 0;
   int ovr_cyc = 0;
   int to_cyc = 0;
   logic [7:0] sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: scoreboard pop on handshake, pulse tallies.
   always @(negedge clk) begin
      logic [7:0] e;
      if (io.overrun === 1'b1) ovr_cyc++;
      if (io.timeout_err === 1'b1) to_cyc++;
      if (rst_n && io.pvalid === 1'b1 && io.pready === 1'b1) begin
         if (sb.size() == 0) chk("sb_unexpected_word", 32'(io.pdata), 32'hDEAD);
         else begin
            e = sb.pop_front();
            chk("sb_pdata", 32'(io.pdata), 32'(e));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] w, input int gap);
      for (int i = 7; i >= 0; i--) begin
         for (int g = 0; g < gap; g++) begin
            tick();
            chk("busy_gap", 32'(io.busy), 1);
         end
         io.sval = 1'b1;
         io.sdata = w[i];
         tick();
         io.sval = 1'b0;
         io.sdata = 1'b0;
         chk("busy_bit", 32'(io.busy), 1);
         chk("pvalid_latency", 32'(io.pvalid), (i == 0) ? 1 : 0);
      end
      chk("pdata_frame", 32'(io.pdata), 32'(w));
   endtask

   task automatic send_frame(input logic [7:0] w, input int gap);
      sb.push_back(w);
      io.start = 1'b1;
      tick();
      io.start = 1'b0;
      chk("busy_start", 32'(io.busy), 1);
      send_bits(w, gap);
   endtask

   task automatic handshake();
      io.pready = 1'b1;
      tick();
      io.pready = 1'b0;
      chk("pvalid_after_hs", 32'(io.pvalid), 0);
      chk("busy_after_hs", 32'(io.busy), 0);
   endtask

   initial begin
      io.start = 1'b0; io.sdata = 1'b0; io.sval = 1'b0; io.pready = 1'b0;
      // Reset state
      tick(); tick();
      chk("rst_pdata", 32'(io.pdata), 0);
      chk("rst_pvalid", 32'(io.pvalid), 0);
      chk("rst_busy", 32'(io.busy), 0);
      chk("rst_overrun", 32'(io.overrun), 0);
      chk("rst_timeout", 32'(io.timeout_err), 0);
      rst_n = 1'b1;
      tick();

      // 1: basic frame B2
      send_frame(8'hB2, 0);

      // 2: consumer stalls 5 clocks
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("hold_pdata", 32'(io.pdata), 32'hB2);
         chk("hold_pvalid", 32'(io.pvalid), 1);
      end
      handshake();

      // 3: overrun, then back-to-back start with handshake
      send_frame(8'hB2, 0);
      io.start = 1'b1;
      tick();
      io.start = 1'b0;
      chk("overrun_pulse", 32'(io.overrun), 1);
      chk("overrun_still_hold", 32'(io.pvalid), 1);
      tick();
      chk("overrun_one_cycle", 32'(io.overrun), 0);
      chk("overrun_pdata", 32'(io.pdata), 32'hB2);
      io.start = 1'b1; io.pready = 1'b1;
      sb.push_back(8'h5A);
      tick();
      io.start = 1'b0; io.pready = 1'b0;
      chk("b2b_pvalid", 32'(io.pvalid), 0);
      chk("b2b_busy", 32'(io.busy), 1);
      chk("b2b_no_overrun", 32'(io.overrun), 0);
      send_bits(8'h5A, 0);
      handshake();
      chk("overrun_count", 32'(ovr_cyc), 1);

      // 4: gap timeout after 3 bits
      io.start = 1'b1;
      tick();
      io.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         io.sval = 1'b1; io.sdata = 1'b1;
         tick();
      end
      io.sval = 1'b0; io.sdata = 1'b0;
      for (int k = 0; k < 15; k++) tick();
      chk("pre_timeout_busy", 32'(io.busy), 1);
      chk("pre_timeout_flag", 32'(io.timeout_err), 0);
      tick();
      chk("timeout_pulse", 32'(io.timeout_err), 1);
      chk("timeout_idle", 32'(io.busy), 0);
      chk("timeout_no_pvalid", 32'(io.pvalid), 0);
      tick();
      chk("timeout_one_cycle", 32'(io.timeout_err), 0);
      chk("timeout_old_pdata", 32'(io.pdata), 32'h5A);
      chk("timeout_count", 32'(to_cyc), 1);

      // 5: reset mid-frame
      io.start = 1'b1;
      tick();
      io.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         io.sval = 1'b1; io.sdata = i[0];
         tick();
      end
      io.sval = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_pdata", 32'(io.pdata), 0);
      chk("midrst_pvalid", 32'(io.pvalid), 0);
      chk("midrst_busy", 32'(io.busy), 0);
      chk("midrst_overrun", 32'(io.overrun), 0);
      chk("midrst_timeout", 32'(io.timeout_err), 0);
      tick();
      rst_n = 1'b1;
      tick();
      send_frame(8'hFF, 0);
      handshake();
      chk("midrst_no_err_pulse", 32'(to_cyc), 1);

      // 6: sval noise in IDLE and HOLD, then 15-clock gaps between bits
      for (int k = 0; k < 4; k++) begin
         io.sval = 1'b1; io.sdata = k[0];
         tick();
         chk("idle_noise_busy", 32'(io.busy), 0);
         chk("idle_noise_pdata", 32'(io.pdata), 32'hFF);
      end
      io.sval = 1'b0;
      send_frame(8'hB2, 0);
      for (int k = 0; k < 4; k++) begin
         io.sval = 1'b1; io.sdata = ~k[0];
         tick();
         chk("hold_noise_pdata", 32'(io.pdata), 32'hB2);
         chk("hold_noise_pvalid", 32'(io.pvalid), 1);
      end
      io.sval = 1'b0;
      handshake();
      send_frame(8'h3C, 15);
      chk("gap15_no_timeout", 32'(to_cyc), 1);
      handshake();

      tick();
      chk("sb_drained", 32'(sb.size()), 0);
      chk("overrun_final", 32'(ovr_cyc), 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
